inst_fetch: RTL and testbench

- Instruction fetch stage that sits directly upstream of the 4096 x 32 synchronous-read instruction memory.
- Owns the program counter and drives the memory address.
- Captures the read data one cycle later and presents {pc, instruction} to decode over a valid/ready handshake.
- Handles decode stalls with a 2-entry skid buffer, and branch/jump redirects by flushing the buffer and the in-flight read.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 49 ++++
 rtl/inst_fetch.sv | 103 ++++++++++
 tb/tb_inst_fetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: widths, FSM states and the
// {pc, instruction} entry that travels from the fetch stage to decode.
package fetch_pkg;

  localparam int FETCH_WIDTH    = 32;
  localparam int FETCH_ADDRSIZE = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDRSIZE-1:0] pc;
    logic [FETCH_WIDTH-1:0]    data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of fetched {pc, instruction} pairs. The head is always
// presented; flush empties the buffer and wins over a simultaneous push.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         valid
);

  fetch_entry_t [1:0] ent_q;
  logic               wr_ptr, rd_ptr;

  // Storage, pointers and occupancy; pop is only ever asserted while non-empty
  // and push only while not full, so no guard is needed here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        ent_q[wr_ptr] <= push_entry;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = ent_q[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to a synchronous-read
// instruction memory, tags returning words with their PC and hands them to
// decode through a 2-entry skid buffer. Redirects flush everything in flight.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int                  WIDTH    = FETCH_WIDTH,
  parameter int                  ADDRSIZE = FETCH_ADDRSIZE,
  parameter logic [ADDRSIZE-1:0] RESET_PC = '0,
  parameter int                  DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt,
  input  logic                redirect_valid,
  input  logic [ADDRSIZE-1:0] redirect_pc,
  output logic [ADDRSIZE-1:0] mem_addr,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [WIDTH-1:0]    inst_data,
  output logic [ADDRSIZE-1:0] inst_pc,
  output logic                busy
);

  // Buffer capacity used by the issue rule; the buffer itself is fixed at 2.
  localparam logic [2:0] CAP = 3'(DEPTH);

  fetch_state_t        state_q, state_d;
  logic [ADDRSIZE-1:0] pc_q, inflight_pc;
  logic                inflight, discard;
  logic                pop, push, issue;
  logic [1:0]          count;
  logic [2:0]          occ;
  fetch_entry_t        push_entry, head;
  logic                head_valid;

  assign pop = head_valid & inst_ready;

  // Entries that will be held after this cycle if nothing is issued now:
  // buffered + in flight - leaving. Issuing only below capacity makes
  // overflow impossible, so the buffer never has to push back.
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state_q == FETCH) & ~halt & ~redirect_valid & (occ < CAP);

  // A word tagged for discard belongs to the pre-redirect stream.
  assign push            = inflight & ~discard;
  assign push_entry.pc   = inflight_pc;
  assign push_entry.data = mem_rdata;

  // Next-state logic; halt together with redirect still lands in HALTED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (halt)  state_d = HALTED;
      HALTED:  if (!halt) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // PC and in-flight tracking; redirect overrides sequential advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      discard     <= 1'b0;
    end else begin
      inflight <= issue;
      discard  <= redirect_valid & inflight;
      if (issue) inflight_pc <= pc_q;
      if (redirect_valid) pc_q <= redirect_pc;
      else if (issue)     pc_q <= pc_q + ADDRSIZE'(1);
    end
  end

  fetch_skid_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (count),
    .valid      (head_valid)
  );

  assign mem_addr   = pc_q;
  assign inst_valid = head_valid;
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;
  assign busy       = (state_q == FETCH) | inflight | (count != 2'd0);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: synchronous memory model, directed scenarios with
// latency checks, and a random phase. A queue-based scoreboard predicts the
// decode-side stream as "sequential PCs from the last start/redirect target".
module tb_inst_fetch;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] mem_addr, inst_pc;
  logic [DW-1:0] mem_rdata, inst_data;
  logic          inst_valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [0:4095];

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          exp_q[$];
  logic [AW-1:0] next_pc = '0;
  int            pops = 0;
  logic [AW-1:0] last_pc = '0;
  logic          saw_wrap = 1'b0;
  logic          hold_prev = 1'b0;
  logic [AW-1:0] prev_pc = '0;
  logic [DW-1:0] prev_data = '0;

  inst_fetch #(.WIDTH(DW), .ADDRSIZE(AW), .RESET_PC(12'h000), .DEPTH(2)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // 4096 x 32 synchronous-read instruction memory
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference stream: keep the next few expected entries queued.
  function automatic void refill();
    exp_t e;
    while (exp_q.size() < 4) begin
      e.pc   = next_pc;
      e.data = 32'(next_pc) + 32'h100;
      exp_q.push_back(e);
      next_pc = next_pc + 12'd1;
    end
  endfunction

  // Monitor: compare every accepted instruction, check head stability under
  // stall, then apply this cycle's redirect to the reference stream.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      next_pc   = 12'h000;
      hold_prev = 1'b0;
      refill();
    end else begin
      if (hold_prev) begin
        chk("hold_pc", 64'(inst_pc), 64'(prev_pc));
        chk("hold_data", 64'(inst_data), 64'(prev_data));
      end
      if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        chk("pop_pc", 64'(inst_pc), 64'(e.pc));
        chk("pop_data", 64'(inst_data), 64'(e.data));
        pops++;
        if (last_pc == 12'hFFF && inst_pc == 12'h000) saw_wrap = 1'b1;
        last_pc = inst_pc;
      end
      chk("count_le_2", 64'(u_dut.count <= 2'd2), 64'(1));
      hold_prev = inst_valid && !inst_ready && !redirect_valid;
      prev_pc   = inst_pc;
      prev_data = inst_data;
      if (redirect_valid) begin
        exp_q.delete();
        next_pc = redirect_pc;
      end
      refill();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Pulse start in the current cycle and verify the 3-cycle first-output latency.
  task automatic start_and_check(input string tag, input logic [AW-1:0] first_pc);
    start = 1'b1; smp();
    tick(); start = 1'b0; smp();
    chk({tag, "_lat1_valid"}, 64'(inst_valid), 64'(0));
    tick(); smp();
    chk({tag, "_lat2_valid"}, 64'(inst_valid), 64'(0));
    tick(); smp();
    chk({tag, "_lat3_valid"}, 64'(inst_valid), 64'(1));
    chk({tag, "_first_pc"}, 64'(inst_pc), 64'(first_pc));
  endtask

  // Redirect in the current cycle, then check flush and first-target latency.
  task automatic redirect_and_check(input string tag, input logic [AW-1:0] tgt);
    redirect_valid = 1'b1; redirect_pc = tgt; smp();
    tick(); redirect_valid = 1'b0; inst_ready = 1'b1; smp();
    chk({tag, "_flush_valid"}, 64'(inst_valid), 64'(0));
    tick(); smp();
    chk({tag, "_r2_valid"}, 64'(inst_valid), 64'(0));
    tick(); smp();
    chk({tag, "_r3_valid"}, 64'(inst_valid), 64'(1));
    chk({tag, "_r3_pc"}, 64'(inst_pc), 64'(tgt));
    chk({tag, "_r3_data"}, 64'(inst_data), 64'(32'(tgt) + 32'h100));
  endtask

  initial begin
    int p0;
    for (int k = 0; k < 4096; k++) mem[k] = 32'(k) + 32'h100;

    // Reset values
    #2;
    chk("rst_valid", 64'(inst_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_pc", 64'(inst_pc), 64'(0));
    chk("rst_data", 64'(inst_data), 64'(0));
    tick(); tick(); reset = 1'b1;
    tick(); tick(); smp();
    chk("idle_valid", 64'(inst_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));

    // Start and stream with no gaps
    tick(); inst_ready = 1'b1;
    start_and_check("start", 12'h000);
    for (int i = 0; i < 12; i++) begin
      tick(); smp();
      chk("stream_no_gap", 64'(inst_valid), 64'(1));
    end

    // Stall 5 cycles: buffer fills, issue stops, head held (monitor)
    tick(); inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); end
    smp();
    chk("stall_count", 64'(u_dut.count), 64'(2));
    chk("stall_issue", 64'(u_dut.issue), 64'(0));
    tick(); inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Redirect with a read in flight during streaming
    smp();
    chk("redir_pre_inflight", 64'(u_dut.inflight), 64'(1));
    tick();
    redirect_and_check("redir80", 12'h080);
    for (int i = 0; i < 6; i++) tick();

    // Redirect with a full buffer under stall
    inst_ready = 1'b0;
    tick(); tick(); tick(); smp();
    chk("redir_full_count", 64'(u_dut.count), 64'(2));
    tick();
    redirect_and_check("redir40", 12'h040);
    for (int i = 0; i < 4; i++) tick();

    // Wrap-around of the PC
    saw_wrap = 1'b0;
    redirect_and_check("wrap", 12'hFFE);
    for (int i = 0; i < 6; i++) tick();
    smp();
    chk("wrap_seen", 64'(saw_wrap), 64'(1));

    // Halt for 4 cycles while streaming: drain then idle-ish
    tick(); halt = 1'b1;
    p0 = pops;
    for (int i = 0; i < 3; i++) tick();
    smp();
    chk("halt_valid", 64'(inst_valid), 64'(0));
    chk("halt_busy", 64'(busy), 64'(0));
    chk("halt_drained", 64'(pops - p0 >= 1), 64'(1));
    tick(); halt = 1'b0;
    p0 = pops;
    for (int i = 0; i < 10; i++) tick();
    smp();
    chk("halt_resume", 64'(pops - p0 >= 6), 64'(1));

    // Asynchronous reset between edges
    tick(); #2; reset = 1'b0; #1;
    chk("arst_valid", 64'(inst_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_addr", 64'(mem_addr), 64'(0));
    chk("arst_pc", 64'(inst_pc), 64'(0));
    chk("arst_data", 64'(inst_data), 64'(0));
    smp(); #2; reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); smp();
      chk("arst_no_output", 64'(inst_valid), 64'(0));
    end
    tick();
    start_and_check("restart", 12'h000);

    // Random traffic: stalls, redirects, halts, stray starts
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      tick();
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = 12'($urandom_range(0, 4095));
      start          = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 49) == 0) halt = ~halt;
    end
    tick();
    redirect_valid = 1'b0; start = 1'b0; halt = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    smp();
    chk("random_progress", 64'(pops - p0 > 300), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
